// File: rtl/poly_voice_engine.sv
// Polyphonic square-wave voice engine: allocates note-on events to NUM_VOICES
// oscillators (retrigger, lowest idle, else steal oldest) and outputs a registered mix.
module poly_voice_engine #(
    parameter  int NUM_VOICES = 4,
    parameter  int PERIOD_W   = 16,
    parameter  int ID_W       = 7,
    localparam int MIX_W      = $clog2(NUM_VOICES + 1),
    localparam int PTR_W      = $clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  on_valid,
    output logic                  on_ready,
    input  logic [ID_W-1:0]       on_id,
    input  logic [PERIOD_W-1:0]   on_half_period,
    input  logic                  off_valid,
    input  logic [ID_W-1:0]       off_id,
    output logic [NUM_VOICES-1:0] voice_busy,
    output logic [MIX_W-1:0]      mix_out,
    output logic                  stolen
);

    typedef enum logic [1:0] {IDLE, SEARCH, LOAD} state_t;

    state_t                state, next_state;
    logic [ID_W-1:0]       lat_id;
    logic [PERIOD_W-1:0]   lat_half;
    logic [PTR_W-1:0]      steal_ptr, target, pick, match_idx, idle_idx;
    logic                  pick_steal, found_match, found_idle, handshake;
    logic [MIX_W-1:0]      mix_next;

    logic [ID_W-1:0]       v_id   [NUM_VOICES];
    logic [PERIOD_W-1:0]   v_half [NUM_VOICES];
    logic [PERIOD_W-1:0]   v_cnt  [NUM_VOICES];
    logic [NUM_VOICES-1:0] v_phase;

    assign handshake = on_valid && on_ready;

    // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        found_match = 1'b0;
        found_idle  = 1'b0;
        match_idx   = '0;
        idle_idx    = '0;
        pick        = steal_ptr;
        pick_steal  = 1'b0;
        // Descending scan so the lowest matching/idle index wins.
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voice_busy[i] && v_id[i] == lat_id) begin
                found_match = 1'b1;
                match_idx   = PTR_W'(i);
            end
            if (!voice_busy[i]) begin
                found_idle = 1'b1;
                idle_idx   = PTR_W'(i);
            end
        end
        if (found_match) begin
            pick = match_idx;
        end else if (found_idle) begin
            pick = idle_idx;
        end else begin
            pick_steal = 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (handshake) next_state = SEARCH;
            SEARCH:  next_state = (lat_half == '0) ? IDLE : LOAD;
            LOAD:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            on_ready  <= 1'b0;
            stolen    <= 1'b0;
            steal_ptr <= '0;
            target    <= '0;
            lat_id    <= '0;
            lat_half  <= '0;
        end else begin
            state    <= next_state;
            // Registered so on_ready stays low through reset and rises the cycle after release.
            on_ready <= (next_state == IDLE);
            stolen   <= (state == SEARCH) && (lat_half != '0) && pick_steal;
            if (handshake) begin
                lat_id   <= on_id;
                lat_half <= on_half_period;
            end
            if (state == SEARCH) begin
                target <= pick;
            end
            if (state == LOAD && stolen) begin
                steal_ptr <= (steal_ptr == PTR_W'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        mix_next = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            mix_next = mix_next + MIX_W'(voice_busy[i] & v_phase[i]);
        end
    end

    // NOTE: the per-voice registers are a handful of flops, not a RAM, so they are all reset to a clean idle state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                v_id[i]   <= '0;
                v_half[i] <= '0;
                v_cnt[i]  <= '0;
            end
            v_phase    <= '0;
            voice_busy <= '0;
            mix_out    <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                // Load takes priority over a same-cycle note-off of the same voice.
                if (state == LOAD && target == PTR_W'(i)) begin
                    v_id[i]       <= lat_id;
                    v_half[i]     <= lat_half;
                    v_cnt[i]      <= '0;
                    v_phase[i]    <= 1'b0;
                    voice_busy[i] <= 1'b1;
                end else if (off_valid && voice_busy[i] && v_id[i] == off_id) begin
                    v_cnt[i]      <= '0;
                    v_phase[i]    <= 1'b0;
                    voice_busy[i] <= 1'b0;
                end else if (voice_busy[i]) begin
                    if (v_cnt[i] == v_half[i] - PERIOD_W'(1)) begin
                        v_cnt[i]   <= '0;
                        v_phase[i] <= ~v_phase[i];
                    end else begin
                        v_cnt[i] <= v_cnt[i] + PERIOD_W'(1);
                    end
                end
            end
            mix_out <= mix_next;
        end
    end

endmodule

// File: tb/tb_poly_voice_engine.sv
// Directed bench for poly_voice_engine: allocation, stealing, retrigger,
// note-off, zero period, and reset/load corner cases with hand-computed expectations.
module tb_poly_voice_engine;

    localparam int NV = 4;
    localparam int PW = 16;
    localparam int IW = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          on_valid = 1'b0;
    logic          on_ready;
    logic [IW-1:0] on_id = '0;
    logic [PW-1:0] on_half_period = '0;
    logic          off_valid = 1'b0;
    logic [IW-1:0] off_id = '0;
    logic [NV-1:0] voice_busy;
    logic [2:0]    mix_out;
    logic          stolen;

    int vecs = 0;
    int errs = 0;

    poly_voice_engine #(.NUM_VOICES(NV), .PERIOD_W(PW), .ID_W(IW)) dut (
        .clk(clk), .reset(reset),
        .on_valid(on_valid), .on_ready(on_ready), .on_id(on_id), .on_half_period(on_half_period),
        .off_valid(off_valid), .off_id(off_id),
        .voice_busy(voice_busy), .mix_out(mix_out), .stolen(stolen)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset;
        reset = 1'b0; on_valid = 1'b0; off_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Issues one note-on from IDLE; returns just after the LOAD edge. st = stolen seen in LOAD.
    task automatic note_on(input logic [IW-1:0] id, input logic [PW-1:0] hp,
                           input bit off_at_load, output bit st);
        vecs++;
        if (on_ready !== 1'b1) begin
            errs++; $display("FAIL on_ready_before_req id=%0d got %b exp 1", id, on_ready);
        end
        on_valid = 1'b1; on_id = id; on_half_period = hp;
        @(negedge clk);
        on_valid = 1'b0;
        @(negedge clk);
        st = stolen;
        if (off_at_load) begin off_valid = 1'b1; off_id = id; end
        @(negedge clk);
        off_valid = 1'b0;
    endtask

    task automatic note_off(input logic [IW-1:0] id);
        off_valid = 1'b1; off_id = id;
        @(negedge clk);
        off_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vecs++; if (voice_busy !== 4'b0000) begin errs++; $display("FAIL reset_busy got %b exp 0000", voice_busy); end
        vecs++; if (mix_out !== 3'd0) begin errs++; $display("FAIL reset_mix got %0d exp 0", mix_out); end
        vecs++; if (on_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got %b exp 0", on_ready); end
        vecs++; if (stolen !== 1'b0) begin errs++; $display("FAIL reset_stolen got %b exp 0", stolen); end
        reset = 1'b1;
        @(negedge clk);
        vecs++; if (on_ready !== 1'b1) begin errs++; $display("FAIL ready_after_release got %b exp 1", on_ready); end
    endtask

    task automatic test_single_note;
        bit st;
        logic [2:0] exp_mix;
        do_reset();
        note_on(7'd10, 16'd3, 1'b0, st);
        vecs++; if (voice_busy !== 4'b0001) begin errs++; $display("FAIL single_busy got %b exp 0001", voice_busy); end
        vecs++; if (st !== 1'b0) begin errs++; $display("FAIL single_stolen got %b exp 0", st); end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_mix = 3'(((k - 1) / 3) % 2);
            vecs++;
            if (mix_out !== exp_mix) begin
                errs++; $display("FAIL single_mix k=%0d got %0d exp %0d", k, mix_out, exp_mix);
            end
        end
    endtask

    task automatic test_steal;
        bit st;
        logic [NV-1:0] exp_busy;
        do_reset();
        for (int n = 0; n < NV; n++) begin
            note_on(IW'(n + 1), 16'd5, 1'b0, st);
            exp_busy = NV'((1 << (n + 1)) - 1);
            vecs++; if (st !== 1'b0) begin errs++; $display("FAIL fill_stolen n=%0d got %b exp 0", n, st); end
            vecs++; if (voice_busy !== exp_busy) begin errs++; $display("FAIL fill_busy n=%0d got %b exp %b", n, voice_busy, exp_busy); end
        end
        note_on(7'd50, 16'd5, 1'b0, st);
        vecs++; if (st !== 1'b1) begin errs++; $display("FAIL steal1_pulse got %b exp 1", st); end
        vecs++; if (stolen !== 1'b0) begin errs++; $display("FAIL steal1_pulse_width got %b exp 0", stolen); end
        vecs++; if (voice_busy !== 4'b1111) begin errs++; $display("FAIL steal1_busy got %b exp 1111", voice_busy); end
        note_on(7'd60, 16'd5, 1'b0, st);
        vecs++; if (st !== 1'b1) begin errs++; $display("FAIL steal2_pulse got %b exp 1", st); end
        note_off(7'd50);
        vecs++; if (voice_busy !== 4'b1110) begin errs++; $display("FAIL off50_busy got %b exp 1110", voice_busy); end
        note_off(7'd1);
        vecs++; if (voice_busy !== 4'b1110) begin errs++; $display("FAIL off1_nomatch got %b exp 1110", voice_busy); end
        note_off(7'd60);
        vecs++; if (voice_busy !== 4'b1100) begin errs++; $display("FAIL off60_busy got %b exp 1100", voice_busy); end
        note_off(7'd3);
        vecs++; if (voice_busy !== 4'b1000) begin errs++; $display("FAIL off3_busy got %b exp 1000", voice_busy); end
    endtask

    task automatic test_retrigger;
        bit st;
        do_reset();
        note_on(7'd7, 16'd100, 1'b0, st);
        note_on(7'd8, 16'd100, 1'b0, st);
        note_on(7'd10, 16'd2, 1'b0, st);
        vecs++; if (voice_busy !== 4'b0111) begin errs++; $display("FAIL retrig_setup got %b exp 0111", voice_busy); end
        repeat (3) @(negedge clk);
        note_on(7'd10, 16'd3, 1'b0, st);
        vecs++; if (st !== 1'b0) begin errs++; $display("FAIL retrig_stolen got %b exp 0", st); end
        vecs++; if (voice_busy !== 4'b0111) begin errs++; $display("FAIL retrig_busy got %b exp 0111", voice_busy); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            vecs++;
            if (mix_out !== ((k >= 4) ? 3'd1 : 3'd0)) begin
                errs++; $display("FAIL retrig_mix k=%0d got %0d exp %0d", k, mix_out, (k >= 4) ? 1 : 0);
            end
        end
        note_off(7'd10);
        vecs++; if (voice_busy !== 4'b0011) begin errs++; $display("FAIL retrig_off_busy got %b exp 0011", voice_busy); end
        @(negedge clk);
        vecs++; if (mix_out !== 3'd0) begin errs++; $display("FAIL retrig_off_mix got %0d exp 0", mix_out); end
    endtask

    task automatic test_zero_period;
        vecs++; if (on_ready !== 1'b1) begin errs++; $display("FAIL zero_ready_pre got %b exp 1", on_ready); end
        on_valid = 1'b1; on_id = 7'd33; on_half_period = 16'd0;
        @(negedge clk);
        on_valid = 1'b0;
        vecs++; if (on_ready !== 1'b0) begin errs++; $display("FAIL zero_ready_search got %b exp 0", on_ready); end
        @(negedge clk);
        vecs++; if (on_ready !== 1'b1) begin errs++; $display("FAIL zero_ready_back got %b exp 1", on_ready); end
        vecs++; if (stolen !== 1'b0) begin errs++; $display("FAIL zero_stolen got %b exp 0", stolen); end
        vecs++; if (voice_busy !== 4'b0011) begin errs++; $display("FAIL zero_busy got %b exp 0011", voice_busy); end
        @(negedge clk);
        vecs++; if (voice_busy !== 4'b0011) begin errs++; $display("FAIL zero_busy_later got %b exp 0011", voice_busy); end
    endtask

    task automatic test_off_at_load;
        bit st;
        do_reset();
        note_on(7'd20, 16'd5, 1'b1, st);
        vecs++; if (voice_busy !== 4'b0001) begin errs++; $display("FAIL off_at_load_busy got %b exp 0001", voice_busy); end
        @(negedge clk);
        vecs++; if (voice_busy !== 4'b0001) begin errs++; $display("FAIL off_at_load_hold got %b exp 0001", voice_busy); end
    endtask

    task automatic test_reset_in_search;
        bit st;
        do_reset();
        note_on(7'd5, 16'd1, 1'b0, st);
        vecs++; if (voice_busy !== 4'b0001) begin errs++; $display("FAIL rs_setup got %b exp 0001", voice_busy); end
        on_valid = 1'b1; on_id = 7'd6; on_half_period = 16'd4;
        @(negedge clk);
        on_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        vecs++; if (voice_busy !== 4'b0000) begin errs++; $display("FAIL rs_busy got %b exp 0000", voice_busy); end
        vecs++; if (mix_out !== 3'd0) begin errs++; $display("FAIL rs_mix got %0d exp 0", mix_out); end
        vecs++; if (on_ready !== 1'b0) begin errs++; $display("FAIL rs_ready got %b exp 0", on_ready); end
        vecs++; if (stolen !== 1'b0) begin errs++; $display("FAIL rs_stolen got %b exp 0", stolen); end
        reset = 1'b1;
        @(negedge clk);
        vecs++; if (on_ready !== 1'b1) begin errs++; $display("FAIL rs_ready_release got %b exp 1", on_ready); end
        repeat (3) @(negedge clk);
        vecs++; if (voice_busy !== 4'b0000) begin errs++; $display("FAIL rs_no_load got %b exp 0000", voice_busy); end
    endtask

    task automatic test_back_to_back;
        logic          exp_ready [7];
        logic [NV-1:0] exp_busy  [7];
        exp_ready = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_busy  = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0011};
        do_reset();
        on_valid = 1'b1; on_id = 7'd11; on_half_period = 16'd4;
        for (int t = 0; t < 7; t++) begin
            if (t > 0) @(negedge clk);
            if (t == 3) on_id = 7'd12;
            vecs++;
            if (on_ready !== exp_ready[t] || voice_busy !== exp_busy[t]) begin
                errs++;
                $display("FAIL b2b t=%0d got ready=%b busy=%b exp ready=%b busy=%b",
                         t, on_ready, voice_busy, exp_ready[t], exp_busy[t]);
            end
        end
        on_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_steal();
        test_retrigger();
        test_zero_period();
        test_off_at_load();
        test_reset_in_search();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
